seqdet_ctrl: RTL
================

Name: seqdet_ctrl

Overview:
Programmable serial sequence-detector controller. It accepts a pattern configuration through a ready/valid port, arms on a start strobe, and scans a qualified serial bit stream for that pattern. It counts matches and ends the run on a match-count target, a bit-window limit or an abort. It is the configurable, run-controlled successor to the fixed-pattern Moore detectors in the serial-protocol path.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of cfg_len; must hold PAT_W
CNT_W, 8, width of match counter and match target
WIN_W, 16, width of bit counter and window limit

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  config offer
cfg_ready  output  1  config accepted when high with cfg_valid
cfg_pattern  input  PAT_W  pattern; bit [cfg_len-1] is the first serial bit
cfg_len  input  LEN_W  pattern length; valid range 1..PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  matches to finish; 0 = unlimited
cfg_window  input  WIN_W  bits to scan; 0 = unlimited
start  input  1  arm request (one-cycle strobe)
abort  input  1  stop the run, no done
x  input  1  serial data bit
x_valid  input  1  x qualifier
busy  output  1  run active
z  output  1  one-cycle match pulse
done  output  1  one-cycle run-complete pulse
done_hit  output  1  1 = target reached, 0 = window expired; held until next start
err  output  1  one-cycle pulse: start rejected
match_cnt  output  CNT_W  matches this run; saturating; held after done
bit_cnt  output  WIN_W  valid bits this run; saturating; held after done

Behaviour:
- Reset: state IDLE; all outputs 0 except cfg_ready=1; config registers, history and fill cleared.
- FSM states: IDLE, RUN, DONE.
- cfg_ready = (state==IDLE). Config is registered on cfg_valid&&cfg_ready. Offers in RUN or DONE are not accepted.
- IDLE + start:
  - cfg_len==0 or cfg_len>PAT_W -> err=1 next cycle; stay IDLE.
  - Otherwise -> RUN. Clear history, fill, match_cnt, bit_cnt, done_hit.
  - start and cfg handshake in the same cycle: the run uses the newly accepted config.
- RUN, per cycle with x_valid=1:
  - hist <= {hist[PAT_W-2:0], x}; fill increments, saturating at cfg_len; bit_cnt++ (saturating).
  - Match when new fill>=cfg_len and the low cfg_len bits of the new hist equal the low cfg_len bits of the pattern.
  - On match: z=1 next cycle; match_cnt++ (saturating). If cfg_overlap=0, fill <= 0.
- Cycles with x_valid=0 change nothing.
- Termination, evaluated on the same bit:
  - target!=0 and new match_cnt==target -> DONE, done_hit=1.
  - Else window!=0 and new bit_cnt==window -> DONE, done_hit=0.
  - Both on the same bit: done_hit=1.
- Latency: bit sampled at cycle t -> z, done, state change visible at t+1.
- DONE lasts exactly one cycle (done=1), then IDLE. start in DONE is ignored.
- busy=1 in RUN and DONE.
- abort in RUN or DONE -> IDLE next cycle; done=0, z=0; counters hold. abort beats termination and start in the same cycle.
- abort or start in RUN: start is ignored.
- rst mid-run -> full reset values next cycle.
- target=0 and window=0 -> runs until abort.

Decomposition:
- Package seqdet_pkg: state enum (IDLE/RUN/DONE), default parameter constants.
- Sub-module seqdet_match: shift history, fill count, length-masked compare, overlap clear. It outputs the match hit combinationally to the controller.

Test Plan:
- Overlap match: pattern 5'b10110, len 5, overlap=1, target 2, window 0; stream 1,0,1,1,0,1,1,0 -> z after bit 4 and after bit 7; done, done_hit=1, match_cnt=2 at bit 7 + 1 cycle.
- Non-overlap: same stream, overlap=0, window 8 -> single z after bit 4; done_hit=0, match_cnt=1, bit_cnt=8.
- Bad length: start with cfg_len=0 and again with cfg_len=9 (PAT_W=8) -> err pulse each time; busy stays 0; cfg_ready stays 1.
- Gapped input: x_valid toggling 1,0,1,0 while streaming 10110 -> match decision unchanged; bit_cnt=5.
- Simultaneous limits: target 1, window 5, stream 10110 -> done_hit=1 on bit 5; abort asserted in the same cycle instead -> IDLE, no done, no z.
- Config gating and reset: cfg_valid during RUN -> cfg_ready=0, old pattern still used; rst mid-run -> busy=0, match_cnt=0, cfg_ready=1 next cycle.

Source files
------------

// File: rtl/seqdet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_pkg
//  Description : Shared types and default sizing for the programmable serial
//                sequence-detector controller (seqdet_ctrl and sub-blocks).
//  Contents    : state_t     - controller state encoding (IDLE/RUN/DONE)
//                c_*_def     - default parameter values
//  Revision    : 1.0 - initial release
// ============================================================================
package seqdet_pkg;

    localparam int c_pat_w_def = 8;    // maximum pattern length in bits
    localparam int c_len_w_def = 4;    // width of the pattern-length field
    localparam int c_cnt_w_def = 8;    // match counter / target width
    localparam int c_win_w_def = 16;   // bit counter / window width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seqdet_pkg
`default_nettype wire

// File: rtl/seqdet_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_ctrl_if
//  Description : Control/config/data bundle of the sequence-detector
//                controller.
//  Modports    : master - the side that configures, arms and feeds bits
//                slave  - the detector itself
//  Signals     : cfg_valid/cfg_ready handshake with cfg_pattern, cfg_len,
//                cfg_overlap, cfg_target, cfg_window; start/abort run
//                control; x/x_valid serial stream; busy, z, done, done_hit,
//                err, match_cnt, bit_cnt status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seqdet_ctrl_if
    import seqdet_pkg::*;
#(
    parameter int PAT_W = c_pat_w_def,
    parameter int LEN_W = c_len_w_def,
    parameter int CNT_W = c_cnt_w_def,
    parameter int WIN_W = c_win_w_def
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic [WIN_W-1:0] cfg_window;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             z;
    logic             done;
    logic             done_hit;
    logic             err;
    logic [CNT_W-1:0] match_cnt;
    logic [WIN_W-1:0] bit_cnt;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
               cfg_window, start, abort, x, x_valid,
        input  cfg_ready, busy, z, done, done_hit, err, match_cnt, bit_cnt
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
               cfg_window, start, abort, x, x_valid,
        output cfg_ready, busy, z, done, done_hit, err, match_cnt, bit_cnt
    );

endinterface : seqdet_ctrl_if
`default_nettype wire

// File: rtl/seqdet_match.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_match
//  Description : Pattern-match datapath. Keeps the serial bit history and a
//                fill count of bits usable for the next match, and compares
//                the low i_len bits of the post-shift history to the pattern.
//  Ports       : clk, rst     - clock / synchronous active-high reset
//                i_clear      - clear history and fill (run arm)
//                i_shift      - accept i_x this cycle
//                i_x          - serial data bit
//                i_pattern    - pattern, low i_len bits significant
//                i_len        - pattern length (1..PAT_W)
//                i_overlap    - 0: a match restarts the fill count
//                o_hit        - combinational: this shifted bit completes
//                               a match
//  Revision    : 1.0 - initial release
// ============================================================================
module seqdet_match
    import seqdet_pkg::*;
#(
    parameter int PAT_W = c_pat_w_def,
    parameter int LEN_W = c_len_w_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_x,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_overlap,
    output logic             o_hit
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;

    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0] w_mask;
    logic             w_eq;

    always_comb begin
        w_hist_nxt = {r_hist[PAT_W-2:0], i_x};
        // Fill saturates at the pattern length: only "enough bits seen"
        // matters for the compare.
        w_fill_nxt = (r_fill >= i_len) ? i_len : r_fill + LEN_W'(1);
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < i_len);
        end
        w_eq  = (((w_hist_nxt ^ i_pattern) & w_mask) == '0);
        o_hit = i_shift && (w_fill_nxt >= i_len) && w_eq;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_nxt;
            // Non-overlapping mode: bits of a matched pattern may not be
            // reused, so counting restarts from the next bit.
            r_fill <= (o_hit && !i_overlap) ? '0 : w_fill_nxt;
        end
    end

endmodule : seqdet_match
`default_nettype wire

// File: rtl/seqdet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seqdet_ctrl
//  Description : Programmable serial sequence-detector controller. Accepts
//                a pattern configuration over a ready/valid handshake, arms
//                on start, scans the qualified bit stream and counts
//                matches; a run ends on a match target, a bit window or an
//                abort.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous, active-high reset
//                bus  - seqdet_ctrl_if.slave (config, run control, serial
//                       stream, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module seqdet_ctrl
    import seqdet_pkg::*;
#(
    parameter int PAT_W = c_pat_w_def,
    parameter int LEN_W = c_len_w_def,
    parameter int CNT_W = c_cnt_w_def,
    parameter int WIN_W = c_win_w_def
) (
    input  logic         clk,
    input  logic         rst,
    seqdet_ctrl_if.slave bus
);

    state_t           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_target;
    logic [WIN_W-1:0] r_window;
    logic             r_cfg_ready;
    logic             r_busy;
    logic             r_z;
    logic             r_done;
    logic             r_done_hit;
    logic             r_err;
    logic [CNT_W-1:0] r_match_cnt;
    logic [WIN_W-1:0] r_bit_cnt;

    logic             w_cfg_fire;
    logic [LEN_W-1:0] w_eff_len;
    logic             w_len_bad;
    logic             w_arm;
    logic             w_shift;
    logic             w_hit;
    logic [CNT_W-1:0] w_mc_nxt;
    logic [WIN_W-1:0] w_bc_nxt;
    logic             w_term_hit;
    logic             w_term_win;

    // A start in the same cycle as a config handshake must validate the
    // length being accepted, not the one currently held.
    assign w_cfg_fire = bus.cfg_valid && r_cfg_ready;
    assign w_eff_len  = w_cfg_fire ? bus.cfg_len : r_len;
    assign w_len_bad  = (w_eff_len == '0) || (w_eff_len > LEN_W'(PAT_W));
    assign w_arm      = (r_state == IDLE) && bus.start && !w_len_bad;
    // Abort wins over the bit presented with it: nothing is shifted/counted.
    assign w_shift    = (r_state == RUN) && bus.x_valid && !bus.abort;

    seqdet_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_arm),
        .i_shift   (w_shift),
        .i_x       (bus.x),
        .i_pattern (r_pattern),
        .i_len     (r_len),
        .i_overlap (r_overlap),
        .o_hit     (w_hit)
    );

    assign w_bc_nxt = (&r_bit_cnt) ? r_bit_cnt : r_bit_cnt + WIN_W'(1);
    assign w_mc_nxt = (w_hit && !(&r_match_cnt)) ? r_match_cnt + CNT_W'(1)
                                                  : r_match_cnt;
    assign w_term_hit = (r_target != '0) && (w_mc_nxt == r_target);
    assign w_term_win = (r_window != '0) && (w_bc_nxt == r_window);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pattern   <= '0;
            r_len       <= '0;
            r_overlap   <= 1'b0;
            r_target    <= '0;
            r_window    <= '0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_z         <= 1'b0;
            r_done      <= 1'b0;
            r_done_hit  <= 1'b0;
            r_err       <= 1'b0;
            r_match_cnt <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_z    <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_cfg_fire) begin
                r_pattern <= bus.cfg_pattern;
                r_len     <= bus.cfg_len;
                r_overlap <= bus.cfg_overlap;
                r_target  <= bus.cfg_target;
                r_window  <= bus.cfg_window;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_len_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            r_cfg_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_match_cnt <= '0;
                            r_bit_cnt   <= '0;
                            r_done_hit  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        r_state     <= IDLE;
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (bus.x_valid) begin
                        r_bit_cnt   <= w_bc_nxt;
                        r_match_cnt <= w_mc_nxt;
                        r_z         <= w_hit;
                        // Target has priority when both limits land on
                        // the same bit.
                        if (w_term_hit || w_term_win) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_done_hit <= w_term_hit;
                        end
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_cfg_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cfg_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.busy      = r_busy;
    assign bus.z         = r_z;
    assign bus.done      = r_done;
    assign bus.done_hit  = r_done_hit;
    assign bus.err       = r_err;
    assign bus.match_cnt = r_match_cnt;
    assign bus.bit_cnt   = r_bit_cnt;

endmodule : seqdet_ctrl
`default_nettype wire
